// File: rtl/fpu_add_align_pipe_pkg.sv
// FPU_192_Package: shared constants and types for the single-precision
// add/subtract front end (fpu_add_align_pipe and its align shifter).
package FPU_192_Package;

    localparam int FORMAT_LENGTH             = 32;
    localparam int EXPONENT_LENGTH           = 8;
    localparam int FRACTION_LENGTH           = 23;
    localparam int NORMALIZE_MANTISSA_LENGTH = 24;

    localparam logic [FORMAT_LENGTH-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [FORMAT_LENGTH-1:0] POS_INF = 32'h7F80_0000;

    // One operand after unpacking: sign, biased exponent, mantissa with hidden bit.
    typedef struct packed {
        logic                                 sign;
        logic [EXPONENT_LENGTH-1:0]           exp;
        logic [NORMALIZE_MANTISSA_LENGTH-1:0] man;
    } fpu_unpacked_t;

    // Split a packed operand; sign_flip lets operand B carry its effective sign.
    function automatic fpu_unpacked_t unpack_operand(
        input logic [FORMAT_LENGTH-1:0] op,
        input logic                     sign_flip
    );
        fpu_unpacked_t u;
        u.sign = op[FORMAT_LENGTH-1] ^ sign_flip;
        u.exp  = op[FORMAT_LENGTH-2:FRACTION_LENGTH];
        u.man  = {(op[FORMAT_LENGTH-2:FRACTION_LENGTH] != '0), op[FRACTION_LENGTH-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/fpu_add_align_pipe_shifter.sv
// fpu_align_shifter: combinational right shifter that aligns the smaller
// mantissa to the larger exponent. Five log levels (1/2/4/8/16); any shift
// of 24 or more clears the result since every bit would fall off the end.
module fpu_align_shifter
    import FPU_192_Package::*;
(
    input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_in,
    input  logic [EXPONENT_LENGTH-1:0]           shift,
    output logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_out
);

    logic [NORMALIZE_MANTISSA_LENGTH-1:0] lvl0, lvl1, lvl2, lvl3, lvl4;
    logic                                 too_far;

    // Log shifter levels followed by the out-of-range clamp.
    always_comb begin
        too_far = (shift >= EXPONENT_LENGTH'(NORMALIZE_MANTISSA_LENGTH));
        lvl0    = shift[0] ? {1'b0,  man_in[23:1]} : man_in;
        lvl1    = shift[1] ? {2'b0,  lvl0[23:2]}   : lvl0;
        lvl2    = shift[2] ? {4'b0,  lvl1[23:4]}   : lvl1;
        lvl3    = shift[3] ? {8'b0,  lvl2[23:8]}   : lvl2;
        lvl4    = shift[4] ? {16'b0, lvl3[23:16]}  : lvl3;
        man_out = too_far ? '0 : lvl4;
    end

endmodule

// File: rtl/fpu_add_align_pipe.sv
// fpu_add_align_pipe: three-stage add/subtract front end.
//   S1 unpack + magnitude swap, S2 align smaller mantissa, S3 mantissa add/sub.
// Outputs {exp, man, cout, sign} feed the post-normalization stage directly.
// One global stall signal holds every stage (empty ones too) while the
// output is full and not accepted.
// Optional feature macro: FPU_SPECIAL_CASE_EN (Inf/NaN detection and the
// out_special / out_special_result ports). Without it, exponent 0xFF is an
// ordinary number.
module fpu_add_align_pipe
    import FPU_192_Package::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [FORMAT_LENGTH-1:0]             op_a,
    input  logic [FORMAT_LENGTH-1:0]             op_b,
    input  logic                                 op_sub,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [EXPONENT_LENGTH-1:0]           exp,
    output logic [NORMALIZE_MANTISSA_LENGTH-1:0] man,
    output logic                                 cout,
    output logic                                 sign
`ifdef FPU_SPECIAL_CASE_EN
   ,output logic                                 out_special,
    output logic [FORMAT_LENGTH-1:0]             out_special_result
`endif
);

    logic advance;

    fpu_unpacked_t                        unp_a, unp_b, big_c, small_c;
    logic                                 a_ge_b;
    logic [EXPONENT_LENGTH-1:0]           d_c;

    logic                                 s1_valid;
    fpu_unpacked_t                        s1_big;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] s1_small_man;
    logic [EXPONENT_LENGTH-1:0]           s1_shift;
    logic                                 s1_effsub;

    logic [NORMALIZE_MANTISSA_LENGTH-1:0] small_al_c;

    logic                                 s2_valid;
    fpu_unpacked_t                        s2_big;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] s2_small_al;
    logic                                 s2_effsub;

    logic [NORMALIZE_MANTISSA_LENGTH:0]   sum_c;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] diff_c;

    // Single stall for the whole pipe; upstream sees it directly as ready.
    always_comb begin
        advance  = ~out_valid | out_ready;
        in_ready = advance;
    end

    // S1 combinational: unpack, order by magnitude (tie keeps A), exponent gap.
    always_comb begin
        unp_a   = unpack_operand(op_a, 1'b0);
        unp_b   = unpack_operand(op_b, op_sub);
        a_ge_b  = (op_a[FORMAT_LENGTH-2:0] >= op_b[FORMAT_LENGTH-2:0]);
        big_c   = a_ge_b ? unp_a : unp_b;
        small_c = a_ge_b ? unp_b : unp_a;
        d_c     = big_c.exp - small_c.exp;
    end

    // S1 register: larger operand, smaller mantissa, shift amount, op kind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_big       <= '0;
            s1_small_man <= '0;
            s1_shift     <= '0;
            s1_effsub    <= 1'b0;
        end else if (advance) begin
            s1_valid     <= in_valid;
            s1_big       <= big_c;
            s1_small_man <= small_c.man;
            s1_shift     <= d_c;
            s1_effsub    <= big_c.sign ^ small_c.sign;
        end
    end

    fpu_align_shifter u_align (
        .man_in  (s1_small_man),
        .shift   (s1_shift),
        .man_out (small_al_c)
    );

    // S2 register: aligned smaller mantissa alongside the larger operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_big      <= '0;
            s2_small_al <= '0;
            s2_effsub   <= 1'b0;
        end else if (advance) begin
            s2_valid    <= s1_valid;
            s2_big      <= s1_big;
            s2_small_al <= small_al_c;
            s2_effsub   <= s1_effsub;
        end
    end

    // S3 combinational: both the sum and the difference; the swap guarantees diff >= 0.
    always_comb begin
        sum_c  = {1'b0, s2_big.man} + {1'b0, s2_small_al};
        diff_c = s2_big.man - s2_small_al;
    end

    // S3 register: result selection, exact cancellation yields +0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            exp       <= '0;
            man       <= '0;
            cout      <= 1'b0;
            sign      <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            exp       <= s2_big.exp;
            if (s2_effsub) begin
                man  <= diff_c;
                cout <= 1'b0;
                sign <= (diff_c == '0) ? 1'b0 : s2_big.sign;
            end else begin
                man  <= sum_c[NORMALIZE_MANTISSA_LENGTH-1:0];
                cout <= sum_c[NORMALIZE_MANTISSA_LENGTH];
                sign <= s2_big.sign;
            end
        end
    end

`ifdef FPU_SPECIAL_CASE_EN
    logic                     a_max, b_max, a_nan, b_nan, a_inf, b_inf, spec_c;
    logic [FORMAT_LENGTH-1:0] spec_res_c;
    logic                     s1_special, s2_special;
    logic [FORMAT_LENGTH-1:0] s1_special_res, s2_special_res;

    // S1 special detection: NaN or Inf-Inf gives QNAN, else a signed infinity.
    always_comb begin
        a_max  = (unp_a.exp == '1);
        b_max  = (unp_b.exp == '1);
        a_nan  = a_max && (op_a[FRACTION_LENGTH-1:0] != '0);
        b_nan  = b_max && (op_b[FRACTION_LENGTH-1:0] != '0);
        a_inf  = a_max && !a_nan;
        b_inf  = b_max && !b_nan;
        spec_c = a_max | b_max;
        if (a_nan || b_nan || (a_inf && b_inf && (unp_a.sign != unp_b.sign))) begin
            spec_res_c = QNAN;
        end else if (a_inf) begin
            spec_res_c = {unp_a.sign, POS_INF[FORMAT_LENGTH-2:0]};
        end else begin
            spec_res_c = {unp_b.sign, POS_INF[FORMAT_LENGTH-2:0]};
        end
    end

    // Special flag and result ride alongside the datapath with equal latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_special         <= 1'b0;
            s1_special_res     <= '0;
            s2_special         <= 1'b0;
            s2_special_res     <= '0;
            out_special        <= 1'b0;
            out_special_result <= '0;
        end else if (advance) begin
            s1_special         <= spec_c;
            s1_special_res     <= spec_res_c;
            s2_special         <= s1_special;
            s2_special_res     <= s1_special_res;
            out_special        <= s2_special;
            out_special_result <= s2_special_res;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_add_align_pipe.sv
// tb_fpu_add_align_pipe: scoreboard bench for fpu_add_align_pipe.
// A driver process feeds queued operand pairs and, on acceptance, pushes the
// expected result; a monitor pops and compares whenever a result transfers.
// Honours FPU_SPECIAL_CASE_EN the same way as the design.
`timescale 1ns/1ps
module tb_fpu_add_align_pipe;
    import FPU_192_Package::*;

    typedef struct {
        logic [7:0]  exp;
        logic [23:0] man;
        logic        cout;
        logic        sign;
        logic        special;
        logic [31:0] special_result;
    } expect_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        expect_t     want;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp;
    logic [23:0] man;
    logic        cout;
    logic        sign;
`ifdef FPU_SPECIAL_CASE_EN
    logic        out_special;
    logic [31:0] out_special_result;
`endif

    stim_t   stim_q[$];
    expect_t exp_q[$];
    int      checks    = 0;
    int      passes    = 0;
    int      out_count = 0;

    fpu_add_align_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp       (exp),
        .man       (man),
        .cout      (cout),
        .sign      (sign)
`ifdef FPU_SPECIAL_CASE_EN
       ,.out_special        (out_special),
        .out_special_result (out_special_result)
`endif
    );

    always #5 clk = ~clk;

    // Compare one value and keep the tallies.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    // Queue an operand pair together with the result it must produce.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub, input expect_t want);
        stim_t s;
        s.a = a; s.b = b; s.sub = sub; s.want = want;
        stim_q.push_back(s);
    endtask

    function automatic expect_t mk(input logic [7:0] e, input logic [23:0] m, input logic c, input logic s);
        expect_t r;
        r = '{default: 0};
        r.exp = e; r.man = m; r.cout = c; r.sign = s;
        return r;
    endfunction

    // Reference: real-number style magnitude ordering, integer align and add/sub.
    function automatic expect_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        expect_t     r;
        int unsigned exp_a, exp_b, man_a, man_b, big_exp, small_exp, big_man, small_man, gap, aligned, total;
        bit          sign_a, sign_b, big_sign, small_sign;
`ifdef FPU_SPECIAL_CASE_EN
        bit          nan, inf_a, inf_b;
`endif
        r = '{default: 0};
        exp_a  = {24'd0, a[30:23]};
        exp_b  = {24'd0, b[30:23]};
        man_a  = {9'd0, a[22:0]} + ((exp_a != 0) ? 32'h80_0000 : 32'd0);
        man_b  = {9'd0, b[22:0]} + ((exp_b != 0) ? 32'h80_0000 : 32'd0);
        sign_a = a[31];
        sign_b = b[31] ^ sub;
        if (a[30:0] >= b[30:0]) begin
            big_exp = exp_a; big_man = man_a; big_sign = sign_a;
            small_exp = exp_b; small_man = man_b; small_sign = sign_b;
        end else begin
            big_exp = exp_b; big_man = man_b; big_sign = sign_b;
            small_exp = exp_a; small_man = man_a; small_sign = sign_a;
        end
        gap     = big_exp - small_exp;
        aligned = (gap >= 24) ? 0 : (small_man >> gap);
        r.exp   = 8'(big_exp);
        if (big_sign == small_sign) begin
            total  = big_man + aligned;
            r.cout = (total >= 32'h100_0000);
            r.man  = 24'(total);
            r.sign = big_sign;
        end else begin
            total  = big_man - aligned;
            r.cout = 1'b0;
            r.man  = 24'(total);
            r.sign = (total == 0) ? 1'b0 : big_sign;
        end
`ifdef FPU_SPECIAL_CASE_EN
        if (exp_a == 255 || exp_b == 255) begin
            nan   = (exp_a == 255 && a[22:0] != 0) || (exp_b == 255 && b[22:0] != 0);
            inf_a = (exp_a == 255 && a[22:0] == 0);
            inf_b = (exp_b == 255 && b[22:0] == 0);
            r.special = 1'b1;
            if (nan || (inf_a && inf_b && sign_a != sign_b)) r.special_result = QNAN;
            else if (inf_a) r.special_result = {sign_a, POS_INF[30:0]};
            else r.special_result = {sign_b, POS_INF[30:0]};
        end
`endif
        return r;
    endfunction

    // Driver: present the head of the stimulus queue, commit it once accepted.
    initial begin : driver
        stim_t cur;
        in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stim_q.size() != 0) begin
                cur = stim_q[0];
                in_valid = 1'b1; op_a = cur.a; op_b = cur.b; op_sub = cur.sub;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (rst_n && in_valid && in_ready && stim_q.size() != 0) begin
                exp_q.push_back(cur.want);
                void'(stim_q.pop_front());
            end
        end
    end

    // Monitor: every transferred result must match the oldest expectation.
    always @(negedge clk) begin : monitor
        expect_t w;
        bit      check_dp;
        if (rst_n && out_valid && out_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_output: got exp=0x%0h man=0x%0h, expected no result", exp, man);
            end else begin
                w = exp_q.pop_front();
                check_dp = 1'b1;
`ifdef FPU_SPECIAL_CASE_EN
                checkOutput("out_special", 32'(out_special), 32'(w.special));
                if (w.special) begin
                    checkOutput("out_special_result", out_special_result, w.special_result);
                    check_dp = 1'b0;
                end
`endif
                if (check_dp) begin
                    checkOutput("exp",  32'(exp),  32'(w.exp));
                    checkOutput("man",  32'(man),  32'(w.man));
                    checkOutput("cout", 32'(cout), 32'(w.cout));
                    checkOutput("sign", 32'(sign), 32'(w.sign));
                end
            end
        end
    end

    // Wait until everything queued has come out, optionally with random backpressure.
    task automatic waitDrain(input int limit, input bit random_ready);
        int n;
        n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
            @(posedge clk); #1;
            if (random_ready) out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        out_ready = 1'b1;
        checkOutput("drain_remaining", 32'(stim_q.size() + exp_q.size()), 0);
    endtask

    task automatic queueRandom(input int count);
        logic [31:0] a, b;
        logic        s;
        int          k;
        for (int i = 0; i < count; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 6);
            if (k == 0) b[30:23] = a[30:23];
            else if (k == 1) b[30:23] = a[30:23] - 8'($urandom_range(1, 26));
            else if (k == 2) b[30:0] = '0;
            else if (k == 3) begin a[30:23] = '0; b[30:23] = '0; end
            else if (k == 4) b[30:0] = a[30:0];
            applyStimulus(a, b, s, ref_model(a, b, s));
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [7:0]  snap_exp;
        logic [23:0] snap_man;
        logic        snap_cout, snap_sign;
        int          base, n;

        rst_n = 1'b0; out_ready = 1'b1;
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_in_ready",  32'(in_ready),  1);
        checkOutput("reset_exp",  32'(exp),  0);
        checkOutput("reset_man",  32'(man),  0);
        checkOutput("reset_cout", 32'(cout), 0);
        checkOutput("reset_sign", 32'(sign), 0);
`ifdef FPU_SPECIAL_CASE_EN
        checkOutput("reset_out_special", 32'(out_special), 0);
        checkOutput("reset_out_special_result", out_special_result, 0);
`endif
        @(posedge clk); #3 rst_n = 1'b1;

        $display("[TB] directed cases");
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, 1'b0, mk(8'h7F, 24'h00_0000, 1'b1, 1'b0));
        applyStimulus(32'h3FC0_0000, 32'h3F80_0000, 1'b1, mk(8'h7F, 24'h40_0000, 1'b0, 1'b0));
        applyStimulus(32'h3F80_0000, 32'h3080_0000, 1'b0, mk(8'h7F, 24'h80_0000, 1'b0, 1'b0));
        applyStimulus(32'hBF80_0000, 32'h3F80_0000, 1'b0, mk(8'h7F, 24'h00_0000, 1'b0, 1'b0));
        applyStimulus(32'h0000_0000, 32'hC040_0000, 1'b0, mk(8'h80, 24'hC0_0000, 1'b0, 1'b1));
        applyStimulus(32'h0040_0000, 32'h0060_0000, 1'b0, mk(8'h00, 24'hA0_0000, 1'b0, 1'b0));
`ifdef FPU_SPECIAL_CASE_EN
        begin
            expect_t sp;
            sp = '{default: 0};
            sp.special = 1'b1; sp.special_result = QNAN;
            applyStimulus(32'h7F80_0000, 32'h7F80_0000, 1'b1, sp);
        end
`endif
        waitDrain(100, 1'b0);

        $display("[TB] random traffic with backpressure");
        queueRandom(300);
        waitDrain(3000, 1'b1);

        $display("[TB] stall with full pipe");
        @(posedge clk); #1 out_ready = 1'b0;
        queueRandom(5);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (in_ready !== 1'b0 && n < 20);
        checkOutput("bp_in_ready",  32'(in_ready),  0);
        checkOutput("bp_out_valid", 32'(out_valid), 1);
        checkOutput("bp_accepted",  32'(exp_q.size()), 3);
        snap_exp = exp; snap_man = man; snap_cout = cout; snap_sign = sign;
        base = out_count;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("bp_hold_exp",  32'(exp),  32'(snap_exp));
        checkOutput("bp_hold_man",  32'(man),  32'(snap_man));
        checkOutput("bp_hold_cout", 32'(cout), 32'(snap_cout));
        checkOutput("bp_hold_sign", 32'(sign), 32'(snap_sign));
        checkOutput("bp_hold_in_ready", 32'(in_ready), 0);
        checkOutput("bp_no_transfer", 32'(out_count - base), 0);
        @(posedge clk); #1 out_ready = 1'b1;
        base = out_count;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("bp_release_rate", 32'(out_count - base), 5);
        waitDrain(50, 1'b0);

        $display("[TB] reset with pairs in flight");
        queueRandom(2);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (exp_q.size() < 2 && n < 20);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 0);
        checkOutput("midreset_in_ready",  32'(in_ready),  1);
        checkOutput("midreset_man",       32'(man),       0);
        stim_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        base = out_count;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("no_stale_results", 32'(out_count - base), 0);
        checkOutput("postreset_out_valid", 32'(out_valid), 0);

        $display("[TB] traffic after reset");
        queueRandom(40);
        waitDrain(500, 1'b1);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fpu_add_align_pipe.md
# fpu_add_align_pipe

Three-stage pipelined add/subtract front end for the single-precision FPU. It unpacks two IEEE-754 operands, swaps them by magnitude, aligns the smaller mantissa, and adds or subtracts the mantissas. It delivers `{exp, man, cout, sign}` straight into the post-normalization stage's `exp`/`man`/`cout`/`sign` inputs. The block applies valid/ready flow control on both sides.

## Interface
Parameters, from `FPU_192_Package`:
- `FORMAT_LENGTH`, default 32: operand width.
- `EXPONENT_LENGTH`, default 8: exponent width.
- `FRACTION_LENGTH`, default 23: stored fraction width.
- `NORMALIZE_MANTISSA_LENGTH`, default 24: mantissa width including the hidden bit.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block accepts the pair this cycle.
- `op_a`  in  32  operand A.
- `op_b`  in  32  operand B.
- `op_sub`  in  1  1 computes A−B, 0 computes A+B.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `exp`  out  8  larger operand's exponent.
- `man`  out  24  low 24 bits of the mantissa sum/difference.
- `cout`  out  1  carry out of the 24-bit add; always 0 on effective subtract.
- `sign`  out  1  result sign.
- `out_special`  out  1  special-case result; present only with `FPU_SPECIAL_CASE_EN`.
- `out_special_result`  out  32  packed special result; present only with `FPU_SPECIAL_CASE_EN`.

## Operation
**Stage S1: unpack, compare, swap**
- Hidden bit = (exponent != 0).
- Effective sign of B = `op_b[31]` ^ `op_sub`.
- Compare magnitudes {exp, fraction}. L = larger operand, S = smaller; on a tie, L = A.
- `d` = expL − expS, 8-bit unsigned.
- `effsub` = signL ^ signS.

**Stage S2: align**
- Aligned mantissa: manS_al = manS >> d.
- If d ≥ 24, manS_al = 0.
- Shifted-out bits are discarded: no guard, round or sticky bits.

**Stage S3: add/subtract**
- `effsub`=0: {cout, man} = manL + manS_al.
- `effsub`=1: man = manL − manS_al, cout = 0. The result is never negative because L ≥ S.
- exp = expL.
- sign = signL, except an exact-cancellation zero (effsub and man == 0), which outputs sign = 0.

**Flow control**
- Global stall: `advance` = ~out_valid | out_ready.
- `in_ready` = `advance`.
- All stage registers, including the per-stage valid bits, load only when `advance` = 1.
- Bubbles do not collapse, so a stall holds every stage, empty ones included.
- A pair transfers when in_valid & in_ready; a result transfers when out_valid & out_ready.

**Boundary conditions**
- d = 0: no shift.
- Zero operand: hidden bit 0, so the result equals the other operand's mantissa and exponent.
- Two denormals: exp = 0 and the add carries into man[23]. This is passed through unchanged.
- Stalled outputs hold every data bit stable.

## Timing
- Latency: 3 cycles from an accepted input to `out_valid`, with no stalls.
- Throughput: 1 pair per cycle while `out_ready` = 1.
- Reset (asynchronous, `rst_n` low):
  - All stage valid bits clear, so `out_valid` = 0 and `in_ready` = 1.
  - `exp`, `man`, `cout`, `sign` = 0.
  - `out_special` = 0 and `out_special_result` = 0.
- Reset mid-operation discards all in-flight pairs. No result emerges for them after `rst_n` deasserts.
- `in_ready` is combinational from `out_ready`. `out_*` are registered.

## Configuration
- `FPU_SPECIAL_CASE_EN` defined:
  - S1 detects exponent 0xFF on either operand and carries a special flag and result down the pipeline with the same latency.
  - NaN in, or Inf − Inf (effective), gives 0x7FC00000.
  - Otherwise an Inf operand gives ±Inf with that operand's effective sign.
  - `out_special` = 1 marks the result; the datapath outputs are don't-care in that case.
- `FPU_SPECIAL_CASE_EN` not defined:
  - Both special ports are absent.
  - Exponent 0xFF is treated as an ordinary normal number.

## Structure
- `FPU_192_Package` holds the length constants above, plus `QNAN` (0x7FC00000) and `POS_INF` (0x7F800000).
- It also holds a typedef `fpu_unpacked_t` {sign, exp[7:0], man[23:0]} used between stages.
- Sub-module `fpu_align_shifter`: combinational 24-bit right barrel shifter with a 5-level log shifter. It forces the output to 0 when d ≥ 24.

## Test plan
- 0x3F800000 + 0x3F800000, op_sub=0 → after 3 cycles: exp=0x7F, man=0x000000, cout=1, sign=0.
- 0x3FC00000 − 0x3F800000 → exp=0x7F, man=0x400000, cout=0, sign=0.
- 0x3F800000 + 0x30800000 (d=30) → exp=0x7F, man=0x800000, cout=0.
- 0xBF800000 + 0x3F800000 → man=0, cout=0, sign=0.
- Backpressure:
  - Stimulus: stream 5 pairs with `out_ready` held low.
  - Response: after 3 accepts `in_ready`=0 and outputs hold stable.
  - Stimulus: release `out_ready`.
  - Response: all 5 results appear in order, one per cycle.
- Reset and special cases:
  - Pulse `rst_n` low with 2 pairs in flight → `out_valid`=0 immediately, and no stale results appear afterwards.
  - With `FPU_SPECIAL_CASE_EN`, 0x7F800000 − 0x7F800000 → `out_special`=1, `out_special_result`=0x7FC00000.
